irq_vec_ctl: RTL and testbench
==============================

Name: irq_vec_ctl

Overview:
CPU-side receiver for level interrupt requests raised by peripheral blocks (VDP vertical-blank irq, UART, timers). Synchronizes the requests, masks them and prioritizes them, then drives the Z8S180 /INT0 line. On a Z80 IM2 acknowledge cycle (/M1 and /IORQ both low) it supplies a vector byte. Sits between the peripheral irq outputs and the CPU bus interface; the ISR clears each source at its owning peripheral, e.g. VDP status read.

Parameters:
NUM_SRC, 4, number of irq sources; legal range 1..7 (index 7 reserved for spurious)
SYNC_STAGES, 2, flop stages on every asynchronous input; minimum 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
irq_src  input  NUM_SRC  asynchronous level requests, active-high, bit 0 = highest priority
m1_n  input  1  asynchronous CPU /M1
iorq_n  input  1  asynchronous CPU /IORQ
int_n  output  1  registered /INT0 to CPU, active-low
vec  output  8  IM2 vector byte, held stable while vec_oe=1
vec_oe  output  1  high while the vector is to be driven on the data bus
reg_wr  input  1  one-clk write tick from the I/O decoder
reg_addr  input  2  register select
reg_din  input  8  write data
reg_dout  output  8  combinational read data for reg_addr

Behaviour:
- Reset is synchronous, active-high. Reset values: irq sync flops 0; m1_n/iorq_n sync flops 1; mask 0; base 0; int_n 1; vec 0x00; vec_oe 0; state IDLE.
- Sync: irq_src, m1_n and iorq_n each pass through SYNC_STAGES flops. s_irq, s_m1_n and s_iorq_n are the synchronized versions.
- pending = s_irq & mask[NUM_SRC-1:0].
- int_n_next = ~|pending. int_n is registered.
- Latency from irq_src rising edge to int_n low is SYNC_STAGES+1 clks. Deassertion has the same latency.
- Priority: idx is the lowest set bit index of pending. If pending is 0, idx = 7 (spurious).
- Vector: {base[3:0], idx[2:0], 1'b0}. Always even, as IM2 requires.
- ack = ~s_m1_n & ~s_iorq_n. ack_d is ack registered one clk.
- FSM IDLE/ACK:
  - IDLE -> ACK on ack & ~ack_d, i.e. the rising edge of ack only. On that transition, latch vec from the current pending and set vec_oe=1.
  - ACK holds vec constant even if pending or mask change.
  - ACK -> IDLE when ack=0, i.e. either strobe synchronized high. vec_oe=0 on the same edge. vec retains its last value.
  - Plain I/O cycles (m1 high) and opcode fetches (iorq high) never enter ACK.
- int_n is not affected by acknowledge. It follows pending only; sources stay asserted until cleared at the peripheral.
- Registers:
  - addr0 MASK: rw, bits [NUM_SRC-1:0]; reads zero-extended.
  - addr1 BASE: rw; a write stores reg_din[7:4]; reads return {base,4'b0}.
  - addr2 RAW: ro, {0, s_irq}, unmasked.
  - addr3 STAT: ro, {vec_oe, 4'b0, idx}, with idx computed live.
  - Writes to addr2 and addr3 are ignored.
- A mask write on clk edge N affects int_n at edge N+1.
- Simultaneous events:
  - A mask write on the same clk as the ack edge: the vector uses the old mask.
  - A source rising during ACK does not alter vec.
- Reset mid-ACK: forces IDLE and vec_oe=0 immediately. Because the sync flops reset to 1, a still-low /M1+/IORQ is re-detected as a new edge after SYNC_STAGES+1 clks. ACK is then re-entered with a fresh vector; the spurious vector 0x?E is used if mask=0.
- Spurious ack (pending=0 at the edge): vec = {base,3'b111,1'b0}, vec_oe=1 as normal.

Decomposition:
- Shared package holds:
  - register address constants REG_MASK=0, REG_BASE=1, REG_RAW=2, REG_STAT=3
  - state encoding ST_IDLE/ST_ACK
  - SPURIOUS_IDX=3'd7
- One sub-module, sync_bus: a WIDTH x SYNC_STAGES synchronizer with a per-instance reset value parameter. Instantiate it once for irq_src (reset 0) and once for {m1_n,iorq_n} (reset 1).
- The priority encoder and FSM stay inline.

Test Plan:
- Reset, mask=0x0F; raise irq_src[2] -> int_n falls exactly 3 clks later; RAW reads 0x04; STAT idx=2.
- base write 0xA0; irq_src=4'b0110; drive m1_n=0 and iorq_n=0 for 6 clks -> vec_oe rises 3 clks after the strobes, vec=0xA2 (idx 1); vec_oe clears 3 clks after iorq_n returns high.
- During ACK, raise irq_src[0] and write mask=0 -> vec stays 0xA2; int_n goes high 1 clk after the mask write.
- mask=0, then an ack cycle -> vec=0xAE (spurious), int_n stays 1 throughout.
- m1_n low with iorq_n high (fetch), then iorq_n low with m1_n high (I/O) -> vec_oe never asserts.
- Assert reset for 1 clk mid-ACK with the strobes held low -> vec_oe=0 next clk; with mask=0 after reset, ACK is re-entered 3 clks later with vec=0x0E.

Source files
------------

// File: rtl/irq_vec_ctl_pkg.sv
// Shared definitions for the interrupt vector controller: register map,
// FSM state encoding and the IM2 vector layout.
package irq_vec_ctl_pkg;

    // Register select values seen on reg_addr
    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_BASE = 2'd1;
    localparam logic [1:0] REG_RAW  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    // Index reported when an acknowledge finds nothing pending
    localparam logic [2:0] SPURIOUS_IDX = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    // IM2 vector: base nibble, source index, and a forced-zero LSB so the
    // vector is always even.
    function automatic logic [7:0] make_vec(input logic [3:0] base,
                                            input logic [2:0] idx);
        return {base, idx, 1'b0};
    endfunction

endpackage

// File: rtl/irq_vec_ctl_if.sv
// Bus bundle between the CPU-side glue and the interrupt vector controller:
// peripheral requests, Z80 strobes, /INT0, vector output and the register port.
interface irq_vec_ctl_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0] irq_src;
    logic               m1_n;
    logic               iorq_n;
    logic               int_n;
    logic [7:0]         vec;
    logic               vec_oe;
    logic               reg_wr;
    logic [1:0]         reg_addr;
    logic [7:0]         reg_din;
    logic [7:0]         reg_dout;

    // Side that drives requests, strobes and register accesses
    modport master (
        output irq_src, m1_n, iorq_n, reg_wr, reg_addr, reg_din,
        input  int_n, vec, vec_oe, reg_dout
    );

    // The controller itself
    modport slave (
        input  irq_src, m1_n, iorq_n, reg_wr, reg_addr, reg_din,
        output int_n, vec, vec_oe, reg_dout
    );
endinterface

// File: rtl/irq_vec_ctl_sync_bus.sv
// WIDTH-bit multi-stage synchronizer for asynchronous level inputs, with a
// per-instance reset value so idle-high strobes come out of reset inactive.
module irq_vec_ctl_sync_bus #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this array is a flop chain, not a RAM, so every stage is
            // reset; otherwise stale values would emerge after reset.
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= RST_VAL;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage take the previous
            // stage's old value; blocking ones would collapse the chain.
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/irq_vec_ctl.sv
// Interrupt vector controller: synchronizes and masks peripheral level
// requests, drives /INT0, and supplies an IM2 vector during /M1+/IORQ
// acknowledge cycles. Sources are cleared at their peripherals, not here.
module irq_vec_ctl
    import irq_vec_ctl_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    irq_vec_ctl_if.slave  bus
);

    logic [NUM_SRC-1:0] w_s_irq;
    logic [1:0]         w_s_strb;
    logic               w_s_m1_n;
    logic               w_s_iorq_n;
    logic [NUM_SRC-1:0] w_pending;
    logic [2:0]         w_idx;
    logic               w_ack;
    logic               w_ack_rise;
    logic               w_vec_load;
    state_t             w_state_next;
    logic [7:0]         w_dout;

    state_t             r_state;
    logic               r_ack_d;
    logic [NUM_SRC-1:0] r_mask;
    logic [3:0]         r_base;
    logic               r_int_n;
    logic [7:0]         r_vec;
    logic               r_vec_oe;

    // Requests come out of reset inactive (low)
    irq_vec_ctl_sync_bus #(
        .WIDTH   (NUM_SRC),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ('0)
    ) u_sync_irq (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.irq_src),
        .o_q   (w_s_irq)
    );

    // Strobes come out of reset inactive (high), so a strobe pair still held
    // low across reset is seen as a fresh acknowledge edge afterwards.
    irq_vec_ctl_sync_bus #(
        .WIDTH   (2),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (2'b11)
    ) u_sync_strb (
        .clk   (clk),
        .reset (reset),
        .i_d   ({bus.m1_n, bus.iorq_n}),
        .o_q   (w_s_strb)
    );

    assign w_s_m1_n   = w_s_strb[1];
    assign w_s_iorq_n = w_s_strb[0];

    assign w_pending  = w_s_irq & r_mask;
    assign w_ack      = ~w_s_m1_n & ~w_s_iorq_n;
    assign w_ack_rise = w_ack & ~r_ack_d;

    // Priority encoder: lowest pending index wins, spurious index if none
    always_comb begin
        // NOTE: assigning a default before the loop keeps this purely
        // combinational; any path leaving w_idx unassigned would infer a latch.
        w_idx = SPURIOUS_IDX;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    // MASK and BASE registers; writes to the read-only addresses are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
            r_base <= '0;
        end else if (bus.reg_wr) begin
            case (bus.reg_addr)
                REG_MASK: r_mask <= bus.reg_din[NUM_SRC-1:0];
                REG_BASE: r_base <= bus.reg_din[7:4];
                default:  ;
            endcase
        end
    end

    // /INT0 follows the masked requests only; acknowledge does not clear it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_int_n <= 1'b1;
        end else begin
            r_int_n <= ~|w_pending;
        end
    end

    // Delayed acknowledge for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_d <= 1'b0;
        end else begin
            r_ack_d <= w_ack;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: enter ACK only on the acknowledge rising edge, leave
    // as soon as either strobe is synchronized high.
    always_comb begin
        w_state_next = r_state;
        w_vec_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ack_rise) begin
                    w_state_next = ST_ACK;
                    w_vec_load   = 1'b1;
                end
            end
            ST_ACK: begin
                if (!w_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Vector capture on ACK entry; held through ACK and retained afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec <= 8'h00;
        end else if (w_vec_load) begin
            r_vec <= make_vec(r_base, w_idx);
        end
    end

    // Vector output enable mirrors the ACK state as a registered signal
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec_oe <= 1'b0;
        end else begin
            r_vec_oe <= (w_state_next == ST_ACK);
        end
    end

    // Combinational register read mux
    always_comb begin
        w_dout = '0;
        case (bus.reg_addr)
            REG_MASK: w_dout[NUM_SRC-1:0] = r_mask;
            REG_BASE: w_dout              = {r_base, 4'b0000};
            REG_RAW:  w_dout[NUM_SRC-1:0] = w_s_irq;
            REG_STAT: w_dout              = {r_vec_oe, 4'b0000, w_idx};
            default:  w_dout              = '0;
        endcase
    end

    assign bus.int_n    = r_int_n;
    assign bus.vec      = r_vec;
    assign bus.vec_oe   = r_vec_oe;
    assign bus.reg_dout = w_dout;

endmodule

// File: tb/tb_irq_vec_ctl.sv
// Self-checking bench for irq_vec_ctl: directed latency/corner scenarios
// followed by randomized mask/base/request/strobe traffic. Expected vectors
// are queued when an acknowledge is issued and checked by an independent
// monitor whenever the controller raises vec_oe.
module tb_irq_vec_ctl;
    import irq_vec_ctl_pkg::*;

    localparam int NSRC = 4;

    logic clk = 1'b0;
    logic reset;

    irq_vec_ctl_if #(.NUM_SRC(NSRC)) bus ();

    irq_vec_ctl #(
        .NUM_SRC     (NSRC),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q [$];

    // Reference model state
    logic [3:0] m_irq;
    logic [3:0] m_mask;
    logic [3:0] m_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lowest set bit of the pending set, 7 when nothing is pending
    function automatic int exp_idx();
        logic [3:0] p;
        p = m_irq & m_mask;
        for (int i = 0; i < NSRC; i++) begin
            if (p[i]) return i;
        end
        return 7;
    endfunction

    function automatic logic [7:0] exp_vec();
        return 8'(m_base * 16 + exp_idx() * 2);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.reg_wr   = 1'b1;
        bus.reg_addr = a;
        bus.reg_din  = d;
        step(1);
        bus.reg_wr   = 1'b0;
        bus.reg_addr = REG_MASK;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus.reg_addr = a;
        #1;
        d = bus.reg_dout;
        bus.reg_addr = REG_MASK;
    endtask

    // Monitor: every vec_oe rise consumes one expected vector; the vector
    // must then stay put for as long as vec_oe is high.
    logic       prev_oe = 1'b0;
    logic [7:0] held    = 8'h00;
    always @(negedge clk) begin
        if (bus.vec_oe === 1'b1 && prev_oe == 1'b0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ack: vec_oe rose with vec=0x%0h, expected no acknowledge (t=%0t)",
                         bus.vec, $time);
            end else begin
                check("ack_vec", bus.vec, exp_q.pop_front());
            end
            held = bus.vec;
        end else if (bus.vec_oe === 1'b1) begin
            check("vec_stable", bus.vec, held);
        end
        prev_oe = (bus.vec_oe === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int kind;
        int hold;

        reset        = 1'b1;
        bus.irq_src  = '0;
        bus.m1_n     = 1'b1;
        bus.iorq_n   = 1'b1;
        bus.reg_wr   = 1'b0;
        bus.reg_addr = REG_MASK;
        bus.reg_din  = 8'h00;
        m_irq = '0; m_mask = '0; m_base = '0;
        step(3);
        reset = 1'b0;

        // Reset state
        check("rst_int_n", bus.int_n, 1'b1);
        check("rst_vec", bus.vec, 8'h00);
        check("rst_vec_oe", bus.vec_oe, 1'b0);
        rd(REG_MASK, d); check("rst_mask", d, 8'h00);
        rd(REG_BASE, d); check("rst_base", d, 8'h00);
        rd(REG_STAT, d); check("rst_stat", d, 8'h07);

        // Request latency: int_n falls exactly 3 clocks after irq_src[2]
        wr(REG_MASK, 8'h0F); m_mask = 4'hF;
        bus.irq_src = 4'b0100; m_irq = 4'b0100;
        step(2); check("lat_int_n_2clk", bus.int_n, 1'b1);
        step(1); check("lat_int_n_3clk", bus.int_n, 1'b0);
        rd(REG_RAW, d);  check("raw_src2", d, 8'h04);
        rd(REG_STAT, d); check("stat_idx2", d, 8'h02);

        // IM2 acknowledge with base 0xA, sources 1 and 2 pending
        wr(REG_BASE, 8'hA0); m_base = 4'hA;
        bus.irq_src = 4'b0110; m_irq = 4'b0110;
        step(4);
        exp_q.push_back(exp_vec());
        bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
        step(2); check("ack_oe_2clk", bus.vec_oe, 1'b0);
        step(1); check("ack_oe_3clk", bus.vec_oe, 1'b1);
        // Mid-ACK: new source and mask cleared; vector must not move
        bus.irq_src = 4'b0111; m_irq = 4'b0111;
        wr(REG_MASK, 8'h00); m_mask = 4'h0;
        check("mask_wr_int_n_same", bus.int_n, 1'b0);
        step(1); check("mask_wr_int_n_next", bus.int_n, 1'b1);
        step(1);
        bus.iorq_n = 1'b1;
        step(2); check("rel_oe_2clk", bus.vec_oe, 1'b1);
        step(1); check("rel_oe_3clk", bus.vec_oe, 1'b0);
        check("vec_retained", bus.vec, 8'hA2);
        rd(REG_STAT, d); check("stat_after_ack", d, 8'h07);
        bus.m1_n = 1'b1;
        step(3);

        // Spurious acknowledge: mask=0, int_n must stay high throughout
        exp_q.push_back(exp_vec());
        bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1); check("spur_int_n", bus.int_n, 1'b1);
        end
        check("spur_oe", bus.vec_oe, 1'b1);
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
        step(4);

        // Opcode fetch and plain I/O never acknowledge
        bus.m1_n = 1'b0;
        step(5); check("fetch_no_oe", bus.vec_oe, 1'b0);
        bus.m1_n = 1'b1;
        step(3);
        bus.iorq_n = 1'b0;
        step(5); check("io_no_oe", bus.vec_oe, 1'b0);
        bus.iorq_n = 1'b1;
        step(3);

        // Reset in the middle of ACK with the strobes still low
        wr(REG_MASK, 8'h0F); m_mask = 4'hF;
        step(1);
        exp_q.push_back(exp_vec());
        bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
        step(4); check("pre_rst_oe", bus.vec_oe, 1'b1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        m_mask = '0; m_base = '0;
        check("midrst_oe", bus.vec_oe, 1'b0);
        check("midrst_vec", bus.vec, 8'h00);
        exp_q.push_back(exp_vec());
        step(2); check("reack_oe_2clk", bus.vec_oe, 1'b0);
        step(1); check("reack_oe_3clk", bus.vec_oe, 1'b1);
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
        step(4);

        // Randomized traffic against the reference model
        for (int it = 0; it < 60; it++) begin
            m_irq = 4'($urandom);
            bus.irq_src = m_irq;
            d = 8'($urandom); wr(REG_MASK, d); m_mask = d[3:0];
            d = 8'($urandom); wr(REG_BASE, d); m_base = d[7:4];
            if ($urandom_range(0, 1) == 1) begin
                wr(2'($urandom_range(2, 3)), 8'($urandom));
            end
            step(4);
            check("rnd_int_n", bus.int_n, (m_irq & m_mask) == 4'h0);
            rd(REG_MASK, d); check("rnd_mask", d, {4'h0, m_mask});
            rd(REG_BASE, d); check("rnd_base", d, {m_base, 4'h0});
            rd(REG_RAW, d);  check("rnd_raw", d, {4'h0, m_irq});
            rd(REG_STAT, d); check("rnd_stat", d, 8'(exp_idx()));

            kind = $urandom_range(0, 3);
            hold = $urandom_range(4, 8);
            if (kind == 0) begin
                exp_q.push_back(exp_vec());
                bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
                step(3);
                m_irq = 4'($urandom);
                bus.irq_src = m_irq;
                d = 8'($urandom); wr(REG_MASK, d); m_mask = d[3:0];
                step(hold - 4);
                bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
            end else if (kind == 1) begin
                bus.m1_n = 1'b0;
                step(hold);
                bus.m1_n = 1'b1;
            end else if (kind == 2) begin
                bus.iorq_n = 1'b0;
                step(hold);
                bus.iorq_n = 1'b1;
            end
            step(4);
            check("rnd_oe_idle", bus.vec_oe, 1'b0);
        end

        step(4);
        check("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
